// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch and load/store ports.
// One transaction in flight; data has priority, bounded by a streak limiter; watchdog aborts stuck requests.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [2:0]  m_funct3,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam int SW = ($clog2(MAX_D_STREAK + 1) < 3) ? 3 : $clog2(MAX_D_STREAK + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wdog;
  logic          d_win;
  logic          i_win;
  logic          expire;

  always_comb begin
    d_win  = d_req & ~(i_req & (streak == STREAK_MAX));
    i_win  = i_req & ~d_win;
    expire = (wdog == WDOG_LAST);
  end

  // Outputs are combinational (same-cycle grant and response pass-through) and gated to 0 in reset.
  always_comb begin
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_funct3 = '0;
    m_addr   = '0;
    m_wdata  = '0;
    err      = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          m_req = i_req | d_req;
          if (d_win) begin
            m_we     = d_we;
            m_funct3 = d_funct3;
            m_addr   = d_addr;
            m_wdata  = d_wdata;
            d_gnt    = m_gnt;
          end else if (i_win) begin
            m_funct3 = 3'b010;
            m_addr   = i_addr;
            i_gnt    = m_gnt;
          end
        end
        BUSY_I: begin
          if (m_rvalid) begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
          end else if (expire) begin
            err = 1'b1;
          end
        end
        BUSY_D: begin
          if (m_rvalid) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
          end else if (expire) begin
            err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      streak <= '0;
      wdog   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Clearing here is equivalent to clearing on BUSY entry, since BUSY is only entered from IDLE.
          wdog <= '0;
          if (d_gnt) begin
            state <= BUSY_D;
            if (!i_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + SW'(1);
          end else if (i_gnt) begin
            state  <= BUSY_I;
            streak <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_rvalid || expire)
            state <= IDLE;
          else
            wdog <= wdog + WW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
